// File: rtl/mul_pipe_pkg.sv
// mul_pipe_pkg: op encoding, word width and operand/result select helpers for mul_pipe
package mul_pipe_pkg;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;
  localparam int WORD_BITS = 32;
  function automatic logic sel_high(op_t op);
    return op != OP_MUL;
  endfunction
  function automatic logic a_signed(op_t op);
    return op != OP_MULHU;
  endfunction
  function automatic logic b_signed(op_t op);
    return op == OP_MUL || op == OP_MULH;
  endfunction
endpackage

// File: rtl/mul_pipe_if.sv
// mul_pipe_if: issue/writeback handshake bundle of the pipelined multiplier
interface mul_pipe_if import mul_pipe_pkg::*; #(parameter int XLEN = 64, parameter int TAG_W = 5);
  logic flush, in_valid, in_ready, in_is_word, out_valid, out_ready, busy;
  op_t in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  modport master (
    output flush, in_valid, in_op, in_is_word, in_a, in_b, in_tag, out_ready,
    input in_ready, out_valid, out_result, out_tag, busy
  );
  modport slave (
    input flush, in_valid, in_op, in_is_word, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/mul_pipe_stage.sv
// mul_pipe_stage: one pipeline register slice carrying valid, op, word flag, tag and payload
module mul_pipe_stage import mul_pipe_pkg::*; #(
  parameter int PW = 130,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             flush,
  input  logic             in_valid,
  input  op_t              in_op,
  input  logic             in_is_word,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [PW-1:0]    in_data,
  output logic             valid,
  output op_t              op,
  output logic             is_word,
  output logic [TAG_W-1:0] tag,
  output logic [PW-1:0]    data
);
  always_ff @(posedge clock)
    if (!reset_n) begin
      valid <= 1'b0;
      op <= OP_MUL;
      is_word <= 1'b0;
      tag <= '0;
      data <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= in_valid;
      op <= in_op;
      is_word <= in_is_word;
      tag <= in_tag;
      data <= in_data;
    end
endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined MUL/MULH/MULHSU/MULHU with word variants, tags, flush and backpressure
module mul_pipe import mul_pipe_pkg::*; #(
  parameter int XLEN = 64,
  parameter int STAGES = 2,
  parameter int TAG_W = 5
) (
  input logic     clock,
  input logic     reset_n,
  mul_pipe_if.slave io
);
  localparam int PW = 2*XLEN+2;
  localparam int L = STAGES-1;
  logic [STAGES-1:0] v;
  op_t op_s [STAGES];
  logic w_s [STAGES];
  logic [TAG_W-1:0] t_s [STAGES];
  logic [PW-1:0] d_s [STAGES];
  logic [PW-1:0] ext;
  logic [XLEN-1:0] sel;
  logic advance, unused_top;
  // payload packs two XLEN+1 signed operands; the product reuses the same width
  function automatic logic [PW-1:0] mulx(logic [PW-1:0] x);
    logic [PW-1:0] a, b;
    a = {{(XLEN+1){x[PW-1]}}, x[PW-1:XLEN+1]};
    b = {{(XLEN+1){x[XLEN]}}, x[XLEN:0]};
    return a * b;
  endfunction
  assign ext = {a_signed(io.in_op) & io.in_a[XLEN-1], io.in_a,
                b_signed(io.in_op) & io.in_b[XLEN-1], io.in_b};
  assign advance = !(io.out_valid && !io.out_ready);
  assign io.in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic v_in, w_in;
    op_t op_in;
    logic [TAG_W-1:0] t_in;
    logic [PW-1:0] d_in;
    if (k == 0) begin : g_first
      assign v_in = io.in_valid;
      assign op_in = io.in_op;
      assign w_in = io.in_is_word;
      assign t_in = io.in_tag;
      assign d_in = STAGES == 1 ? mulx(ext) : ext;
    end else begin : g_rest
      assign v_in = v[k-1];
      assign op_in = op_s[k-1];
      assign w_in = w_s[k-1];
      assign t_in = t_s[k-1];
      assign d_in = k == 1 ? mulx(d_s[k-1]) : d_s[k-1];
    end
    mul_pipe_stage #(.PW(PW), .TAG_W(TAG_W)) u_stage (
      .clock(clock), .reset_n(reset_n), .advance(advance), .flush(io.flush),
      .in_valid(v_in), .in_op(op_in), .in_is_word(w_in), .in_tag(t_in), .in_data(d_in),
      .valid(v[k]), .op(op_s[k]), .is_word(w_s[k]), .tag(t_s[k]), .data(d_s[k])
    );
  end
  assign sel = sel_high(op_s[L]) ? d_s[L][2*XLEN-1:XLEN] : d_s[L][XLEN-1:0];
  assign io.out_result = w_s[L] ? XLEN'($signed(sel[WORD_BITS-1:0])) : sel;
  assign io.out_valid = v[L];
  assign io.out_tag = t_s[L];
  assign io.busy = |v;
  assign unused_top = ^d_s[L][PW-1:2*XLEN];
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed checks of mul_pipe at STAGES=1,2,4 driven in lockstep
module tb_mul_pipe;
  import mul_pipe_pkg::*;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_is_word = 1'b0, out_ready = 1'b1;
  op_t in_op = OP_MUL;
  logic [63:0] in_a = '0, in_b = '0;
  logic [4:0] in_tag = '0;
  logic ov [3], bz [3], irdy [3];
  logic [63:0] ores [3];
  logic [4:0] otag [3];
  int st [3] = '{1, 2, 4};
  int checks = 0, failures = 0;
  for (genvar k = 0; k < 3; k++) begin : g_d
    mul_pipe_if #(.XLEN(64), .TAG_W(5)) io ();
    assign io.flush = flush;
    assign io.in_valid = in_valid;
    assign io.in_op = in_op;
    assign io.in_is_word = in_is_word;
    assign io.in_a = in_a;
    assign io.in_b = in_b;
    assign io.in_tag = in_tag;
    assign io.out_ready = out_ready;
    assign ov[k] = io.out_valid;
    assign bz[k] = io.busy;
    assign irdy[k] = io.in_ready;
    assign ores[k] = io.out_result;
    assign otag[k] = io.out_tag;
    mul_pipe #(.XLEN(64), .STAGES(k == 0 ? 1 : k == 1 ? 2 : 4), .TAG_W(5)) dut (
      .clock(clock), .reset_n(reset_n), .io(io)
    );
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic drive(input op_t op, input logic w, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg);
    in_op = op;
    in_is_word = w;
    in_a = a;
    in_b = b;
    in_tag = tg;
    in_valid = 1'b1;
  endtask
  task automatic run1(input string t, input op_t op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tg, input logic [63:0] exp);
    drive(op, w, a, b, tg);
    tick();
    in_valid = 1'b0;
    chk({t, "_lat1"}, 64'(ov[1]), 64'd0);
    tick();
    chk({t, "_valid"}, 64'(ov[1]), 64'd1);
    chk({t, "_res"}, ores[1], exp);
    chk({t, "_tag"}, 64'(otag[1]), 64'(tg));
    tick();
  endtask
  initial begin
    int ni, nr;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(ov[1]), 64'd0);
    chk("rst_out_result", ores[1], 64'd0);
    chk("rst_out_tag", 64'(otag[1]), 64'd0);
    chk("rst_busy", 64'(bz[1]), 64'd0);
    chk("rst_in_ready", 64'(irdy[1]), 64'd1);
    run1("t1_mul", OP_MUL, 1'b0, 64'd3, -64'sd5, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1);
    run1("t2_mulh", OP_MULH, 1'b0, '1, '1, 5'd1, 64'h0);
    run1("t2_mulhu", OP_MULHU, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run1("t2_mulhsu", OP_MULHSU, 1'b0, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run1("t3_mulw", OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE);
    run1("t3_mulhuw", OP_MULHU, 1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 5'd5, 64'h1);
    ni = 0;
    nr = 0;
    for (int cyc = 0; cyc < 100 && nr < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      if (ni < 8) drive(OP_MUL, 1'b0, 64'(ni + 1), 64'(ni + 2), 5'(ni));
      else in_valid = 1'b0;
      #1;
      if (ov[1]) begin
        chk("t4_res", ores[1], 64'((nr + 1) * (nr + 2)));
        chk("t4_tag", 64'(otag[1]), 64'(nr));
        if (out_ready) nr++;
        else chk("t4_in_ready_stall", 64'(irdy[1]), 64'd0);
      end
      if (in_valid && irdy[1]) ni++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t4_count", 64'(nr), 64'd8);
    chk("t4_no_dup0", 64'(ov[1]), 64'd0);
    tick();
    chk("t4_no_dup1", 64'(ov[1]), 64'd0);
    drive(OP_MUL, 1'b0, 64'd2, 64'd3, 5'd10);
    tick();
    drive(OP_MUL, 1'b0, 64'd4, 64'd5, 5'd11);
    tick();
    chk("t5_pre_valid", 64'(ov[1]), 64'd1);
    chk("t5_pre_busy", 64'(bz[1]), 64'd1);
    drive(OP_MUL, 1'b0, 64'd8, 64'd9, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_flush_valid_s%0d", st[k]), 64'(ov[k]), 64'd0);
      chk($sformatf("t5_flush_busy_s%0d", st[k]), 64'(bz[k]), 64'd0);
    end
    drive(OP_MUL, 1'b0, 64'd6, 64'd7, 5'd9);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t5_lat_s%0d_c%0d", st[k], c), 64'(ov[k]), 64'(c == st[k]));
        if (c == st[k]) begin
          chk($sformatf("t5_res_s%0d", st[k]), ores[k], 64'd42);
          chk($sformatf("t5_tag_s%0d", st[k]), 64'(otag[k]), 64'd9);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    drive(OP_MUL, 1'b0, 64'd5, 64'd5, 5'd3);
    tick();
    drive(OP_MUL, 1'b0, 64'd6, 64'd6, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("t6_pre_valid", 64'(ov[1]), 64'd1);
    chk("t6_pre_res", ores[1], 64'd25);
    reset_n = 1'b0;
    tick();
    chk("t6_out_valid", 64'(ov[1]), 64'd0);
    chk("t6_out_result", ores[1], 64'd0);
    chk("t6_out_tag", 64'(otag[1]), 64'd0);
    chk("t6_busy", 64'(bz[1]), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
